// File: rtl/elevator_scan_controller_if.sv
// Floor-call and car-status bundle for the SCAN elevator controller.
// The controller is the slave; the board/environment side is the master.
interface elevator_scan_controller_if #(
  parameter int unsigned FLOORS = 8,
  parameter int unsigned FW     = $clog2(FLOORS)
);
  logic [FLOORS-1:0] req;
  logic [FW-1:0]     cur_floor;
  logic [FLOORS-1:0] cur_floor_oh;
  logic [FLOORS-1:0] pending;
  logic              dir_up;
  logic              moving;
  logic              door_open;

  modport master (
    output req,
    input  cur_floor, cur_floor_oh, pending, dir_up, moving, door_open
  );

  modport slave (
    input  req,
    output cur_floor, cur_floor_oh, pending, dir_up, moving, door_open
  );
endinterface

// File: rtl/elevator_scan_controller.sv
// Multi-floor elevator controller: latches floor calls and serves them in SCAN
// order, with per-floor travel time and door dwell counters.
module elevator_scan_controller #(
  parameter int unsigned FLOORS       = 8,
  parameter int unsigned TRAVEL_TICKS = 2**24,
  parameter int unsigned DOOR_TICKS   = 2**25,
  parameter int unsigned FW           = $clog2(FLOORS)
) (
  input logic clk,
  input logic rst,
  elevator_scan_controller_if.slave bus
);
  localparam int unsigned TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t            state;
  logic [FW-1:0]     cur_floor;
  logic [FW-1:0]     next_floor;
  logic [FLOORS-1:0] pending;
  logic [FLOORS-1:0] cur_oh;
  logic [FLOORS-1:0] next_oh;
  logic [FLOORS-1:0] clr;
  logic              dir_up;
  logic              moving;
  logic              door_open;
  logic [TW-1:0]     travel_cnt;
  logic [DW-1:0]     door_cnt;
  logic [31:0]       cur_idx;
  logic [31:0]       next_idx;
  logic              above;
  logic              below;
  logic              ahead_next;
  logic              at_cur;
  logic              at_next;
  logic              travel_done;
  logic              door_done;
  logic              rearm;

  assign cur_idx = 32'(cur_floor);
  assign cur_oh  = FLOORS'(1) << cur_floor;

  // Floor the car would occupy after the step in progress; saturates at the shaft ends.
  always_comb begin
    if (dir_up) next_floor = (cur_idx == FLOORS - 1) ? cur_floor : cur_floor + FW'(1);
    else        next_floor = (cur_floor == '0) ? cur_floor : cur_floor - FW'(1);
  end

  assign next_idx    = 32'(next_floor);
  assign next_oh     = FLOORS'(1) << next_floor;
  assign travel_done = (travel_cnt == TW'(TRAVEL_TICKS - 1));
  assign door_done   = (door_cnt == DW'(DOOR_TICKS - 1));
  assign at_cur      = |(pending & cur_oh);
  assign at_next     = |(pending & next_oh);
  assign rearm       = |(bus.req & cur_oh);

  // ahead_next looks past the post-step floor so MOVE can decide on the same edge it steps.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    ahead_next = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending[i]) begin
        if (i > cur_idx) above = 1'b1;
        if (i < cur_idx) below = 1'b1;
        if (dir_up ? (i > next_idx) : (i < next_idx)) ahead_next = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    case (state)
      IDLE:    if (at_cur) clr = cur_oh;
      MOVE:    if (travel_done && at_next) clr = next_oh;
      DOOR:    if (rearm) clr = cur_oh;
      default: clr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_floor  <= '0;
      pending    <= '0;
      dir_up     <= 1'b1;
      moving     <= 1'b0;
      door_open  <= 1'b0;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      pending <= (pending | bus.req) & ~clr;
      case (state)
        IDLE: begin
          if (at_cur) begin
            state     <= DOOR;
            door_open <= 1'b1;
            door_cnt  <= '0;
          end else if (above && (dir_up || !below)) begin
            state      <= MOVE;
            moving     <= 1'b1;
            dir_up     <= 1'b1;
            travel_cnt <= '0;
          end else if (below) begin
            state      <= MOVE;
            moving     <= 1'b1;
            dir_up     <= 1'b0;
            travel_cnt <= '0;
          end
        end
        MOVE: begin
          if (travel_done) begin
            travel_cnt <= '0;
            cur_floor  <= next_floor;
            if (at_next) begin
              state     <= DOOR;
              moving    <= 1'b0;
              door_open <= 1'b1;
              door_cnt  <= '0;
            end else if (!ahead_next) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end else begin
            travel_cnt <= travel_cnt + TW'(1);
          end
        end
        DOOR: begin
          if (rearm) begin
            door_cnt <= '0;
          end else if (door_done) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end else begin
            door_cnt <= door_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == MOVE && travel_done)
      assert (dir_up ? (cur_idx != FLOORS - 1) : (cur_floor != '0))
      else $error("floor step beyond shaft limits");
  end

  assign bus.cur_floor    = cur_floor;
  assign bus.cur_floor_oh = cur_oh;
  assign bus.pending      = pending;
  assign bus.dir_up       = dir_up;
  assign bus.moving       = moving;
  assign bus.door_open    = door_open;
endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scenario bench for elevator_scan_controller; expected stops are queued as
// calls are issued and checked as the car opens its door.
module tb_elevator_scan_controller;
  localparam int unsigned FLOORS = 8;
  localparam int unsigned TRAVEL = 4;
  localparam int unsigned DOOR   = 3;

  typedef struct {
    int unsigned floor;
    int unsigned dwell;
  } stop_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    failures = 0;
  stop_t sb[$];

  elevator_scan_controller_if #(.FLOORS(FLOORS)) bus ();

  elevator_scan_controller #(
    .FLOORS(FLOORS),
    .TRAVEL_TICKS(TRAVEL),
    .DOOR_TICKS(DOOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input int unsigned f);
    bus.req = FLOORS'(1) << f;
    tick();
    bus.req = '0;
  endtask

  task automatic expect_stop(input int unsigned f, input bit front);
    stop_t e;
    e.floor = f;
    e.dwell = DOOR;
    if (front) sb.push_front(e);
    else       sb.push_back(e);
  endtask

  task automatic wait_floor(input int unsigned f, input int budget);
    int n = 0;
    while (32'(bus.cur_floor) != f && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (32'(bus.cur_floor) != f) begin
      failures++;
      $display("FAIL wait_floor cur_floor=%0d required=%0d", bus.cur_floor, f);
    end
  endtask

  task automatic serve_next(input int budget, output int waited);
    stop_t e;
    int    dwell;
    waited = 0;
    while (bus.door_open !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.door_open !== 1'b1) begin
      failures++;
      $display("FAIL door_timeout door_open=%b required=1", bus.door_open);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_stop floor=%0d required=no stop", bus.cur_floor);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (32'(bus.cur_floor) !== e.floor) begin
      failures++;
      $display("FAIL stop_floor cur_floor=%0d required=%0d", bus.cur_floor, e.floor);
    end
    dwell = 1;
    while (dwell < 50) begin
      tick();
      if (bus.door_open === 1'b1) dwell++;
      else break;
    end
    checks++;
    if (dwell != int'(e.dwell)) begin
      failures++;
      $display("FAIL stop_dwell floor=%0d dwell=%0d required=%0d", e.floor, dwell, e.dwell);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.cur_floor !== 3'd0) begin failures++; $display("FAIL rst_cur_floor got=%0d required=0", bus.cur_floor); end
    checks++;
    if (bus.cur_floor_oh !== 8'h01) begin failures++; $display("FAIL rst_cur_floor_oh got=%h required=01", bus.cur_floor_oh); end
    checks++;
    if (bus.pending !== 8'h00) begin failures++; $display("FAIL rst_pending got=%h required=00", bus.pending); end
    checks++;
    if (bus.dir_up !== 1'b1) begin failures++; $display("FAIL rst_dir_up got=%b required=1", bus.dir_up); end
    checks++;
    if (bus.moving !== 1'b0) begin failures++; $display("FAIL rst_moving got=%b required=0", bus.moving); end
    checks++;
    if (bus.door_open !== 1'b0) begin failures++; $display("FAIL rst_door_open got=%b required=0", bus.door_open); end
  endtask

  task automatic test_single_call();
    int w;
    pulse(5);
    expect_stop(5, 1'b0);
    checks++;
    if (bus.pending !== 8'h20) begin failures++; $display("FAIL single_pending got=%h required=20", bus.pending); end
    tick();
    checks++;
    if (bus.moving !== 1'b1) begin failures++; $display("FAIL single_moving got=%b required=1", bus.moving); end
    serve_next(60, w);
    checks++;
    if (w != 20) begin failures++; $display("FAIL single_travel cycles=%0d required=20", w); end
    checks++;
    if (bus.pending !== 8'h00) begin failures++; $display("FAIL single_pending_end got=%h required=00", bus.pending); end
    checks++;
    if (bus.dir_up !== 1'b1 || bus.moving !== 1'b0) begin
      failures++;
      $display("FAIL single_idle dir_up=%b moving=%b required dir_up=1 moving=0", bus.dir_up, bus.moving);
    end
  endtask

  task automatic test_intermediate_stop();
    int w;
    do_reset();
    pulse(7);
    expect_stop(7, 1'b0);
    wait_floor(2, 40);
    pulse(4);
    expect_stop(4, 1'b1);
    serve_next(60, w);
    serve_next(60, w);
    checks++;
    if (bus.pending !== 8'h00 || bus.cur_floor !== 3'd7) begin
      failures++;
      $display("FAIL inter_end pending=%h floor=%0d required pending=00 floor=7", bus.pending, bus.cur_floor);
    end
  endtask

  task automatic test_scan_reversal();
    int w;
    do_reset();
    pulse(6);
    expect_stop(6, 1'b0);
    wait_floor(4, 40);
    pulse(1);
    expect_stop(1, 1'b0);
    serve_next(60, w);
    checks++;
    if (bus.dir_up !== 1'b1 || bus.moving !== 1'b0) begin
      failures++;
      $display("FAIL scan_after6 dir_up=%b moving=%b required dir_up=1 moving=0", bus.dir_up, bus.moving);
    end
    tick();
    checks++;
    if (bus.dir_up !== 1'b0 || bus.moving !== 1'b1) begin
      failures++;
      $display("FAIL scan_reverse dir_up=%b moving=%b required dir_up=0 moving=1", bus.dir_up, bus.moving);
    end
    serve_next(60, w);
    checks++;
    if (w != 20) begin failures++; $display("FAIL scan_down_travel cycles=%0d required=20", w); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scan_leftover stops=%0d required=0", sb.size()); end
  endtask

  task automatic test_door_rearm();
    int w;
    int dwell;
    do_reset();
    pulse(2);
    expect_stop(2, 1'b0);
    serve_next(40, w);
    pulse(2);
    tick();
    checks++;
    if (bus.door_open !== 1'b1 || bus.moving !== 1'b0) begin
      failures++;
      $display("FAIL rearm_open door_open=%b moving=%b required door_open=1 moving=0", bus.door_open, bus.moving);
    end
    dwell = 1;
    while (dwell < 30) begin
      if (dwell == 2) bus.req = FLOORS'(1) << 2;
      tick();
      bus.req = '0;
      if (bus.door_open === 1'b1) dwell++;
      else break;
    end
    checks++;
    if (dwell != 5) begin failures++; $display("FAIL rearm_dwell dwell=%0d required=5", dwell); end
    checks++;
    if (bus.pending !== 8'h00 || bus.cur_floor !== 3'd2) begin
      failures++;
      $display("FAIL rearm_end pending=%h floor=%0d required pending=00 floor=2", bus.pending, bus.cur_floor);
    end
  endtask

  task automatic test_reset_mid_move();
    int activity = 0;
    do_reset();
    pulse(6);
    wait_floor(3, 40);
    checks++;
    if (bus.moving !== 1'b1) begin failures++; $display("FAIL midmove_moving got=%b required=1", bus.moving); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.cur_floor !== 3'd0 || bus.pending !== 8'h00 || bus.moving !== 1'b0 ||
        bus.door_open !== 1'b0 || bus.cur_floor_oh !== 8'h01 || bus.dir_up !== 1'b1) begin
      failures++;
      $display("FAIL midmove_reset floor=%0d pending=%h moving=%b door=%b oh=%h dir_up=%b required 0/00/0/0/01/1",
               bus.cur_floor, bus.pending, bus.moving, bus.door_open, bus.cur_floor_oh, bus.dir_up);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.door_open === 1'b1 || bus.moving === 1'b1) activity++;
    end
    checks++;
    if (activity != 0) begin failures++; $display("FAIL midmove_quiet active_cycles=%0d required=0", activity); end
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_single_call();
    test_intermediate_stop();
    test_scan_reversal();
    test_door_rearm();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Parametrised successor to the single-request elevator core. It tracks any number of floors and latches all outstanding floor calls in a pending register. Service follows SCAN order: keep travelling in the current direction while calls remain ahead, then reverse. It also models travel time and door dwell with internal counters. The block takes raw floor-call inputs from the top-level pins and drives the current-floor display and status outputs.

## Interface
- `FLOORS`, default 8: number of floors; floor 0 is the ground floor; legal range 2..16.
- `TRAVEL_TICKS`, default 2^24: clock cycles to move one floor; minimum 1.
- `DOOR_TICKS`, default 2^25: clock cycles the door stays open per stop; minimum 1.
- `FW`, default $clog2(FLOORS): width of the floor index; derived, never overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  FLOORS  floor-call buttons; bit i = call to floor i; sampled every cycle; pulses of one cycle are sufficient.
- `cur_floor`  out  FW  binary index of the current floor.
- `cur_floor_oh`  out  FLOORS  one-hot current floor, equal to 1 << cur_floor.
- `pending`  out  FLOORS  latched, not-yet-served calls.
- `dir_up`  out  1  1 = travelling or biased upward; 0 = downward.
- `moving`  out  1  high in state MOVE.
- `door_open`  out  1  high in state DOOR.

## Operation
- **Reset values:** cur_floor=0, cur_floor_oh=1, pending=0, dir_up=1, moving=0, door_open=0, state IDLE, counters 0.
- **Pending update:** each cycle, pending <= (pending | req) & ~clr. clr = cur_floor_oh on the cycle DOOR is entered or re-armed, otherwise 0. When the same bit is both set and cleared, clear wins.
- **Definitions:** above = OR of pending bits with index > cur_floor; below = OR of pending bits with index < cur_floor. Both are computed from the registered pending value.
- **IDLE decision, in priority order:**
  - If pending[cur_floor]: go to DOOR and clear that bit.
  - Else if above and (dir_up or not below): go to MOVE with dir_up=1.
  - Else if below: go to MOVE with dir_up=0.
  - Else stay in IDLE; dir_up holds.
- **MOVE:**
  - The travel counter counts 0..TRAVEL_TICKS-1. At the terminal count, cur_floor steps by ±1 per dir_up and the counter restarts.
  - After a step, the next state is evaluated against the new floor:
    - pending[new floor] -> DOOR, clearing that bit.
    - Else a call still ahead in the current direction -> remain in MOVE.
    - Else -> IDLE.
  - cur_floor saturates at 0 and FLOORS-1. A step beyond these limits never occurs and is an assertion failure.
- **DOOR:**
  - The door counter counts 0..DOOR_TICKS-1. At the terminal count, go to IDLE.
  - If req[cur_floor] is asserted while in DOOR, the counter restarts (door re-arm) and the bit stays clear.
- **Output decode:** cur_floor_oh is decoded from the registered cur_floor. All outputs are registered or are decoded only from registers; there are no combinational paths from req.

## Timing
- A req edge k sets pending after edge k. The IDLE decision uses that value, so the state change occurs at edge k+1.
- Response to a current-floor call while IDLE: door_open=1 from edge k+1 onward, with no movement.
- Response to a call on another floor: moving=1 from edge k+1. The first floor step occurs TRAVEL_TICKS cycles after MOVE is entered.
- A floor step and the entry into DOOR at the stop floor happen on the same edge.
- door_open stays high for exactly DOOR_TICKS cycles per stop, or longer if the door is re-armed.
- After DOOR ends, IDLE lasts exactly 1 cycle before the next MOVE or DOOR begins.
- A call arriving in the middle of travel, for a floor ahead of the car, is honoured only if it is latched at least 1 cycle before the step onto that floor. Otherwise the car passes the floor and serves it on the return sweep.
- rst asserted in any state takes effect on the next edge: all outputs return to their reset values, and the counters and pending are cleared.

## Test plan
Parameters for all scenarios: FLOORS=8, TRAVEL_TICKS=4, DOOR_TICKS=3.
- **Reset:** hold rst for 2 cycles, then release -> cur_floor=0, cur_floor_oh=8'h01, pending=0, dir_up=1, moving=0, door_open=0.
- **Single call:** 1-cycle pulse on req[5] at floor 0.
  - pending=8'h20 and moving=1 from the next edge.
  - cur_floor increments every 4 cycles and reaches 5 after 20 MOVE cycles.
  - On arrival, door_open=1 for 3 cycles and pending=0.
  - Then IDLE, with dir_up still 1.
- **Intermediate stop:** moving up from 0 toward 7, pulse req[4] while cur_floor=2.
  - The car stops at 4 with a 3-cycle door.
  - It then continues up to 7, and pending=0 at the end.
- **SCAN reversal:** car at 3 going up with pending={6}, pulse req[1] at floor 4.
  - Stops are served in order 6 then 1.
  - dir_up goes to 0 when MOVE is entered after the floor-6 stop.
- **Door re-arm:** in IDLE at floor 2, pulse req[2].
  - door_open=1 on the next edge with no movement.
  - Pulse req[2] again in the door's 2nd cycle -> door_open lasts 5 cycles in total.
- **Reset mid-move:** assert rst while in MOVE at floor 3 with pending={6} -> on the next edge cur_floor=0, pending=0, moving=0, and no door opening follows.
